// File: rtl/mux_gather_if.sv
// Handshake and data bundle between a lane-sample producer / word consumer
// and the mux_gather block.
interface mux_gather_if #(
    parameter int unsigned SEL_W = 2,
    parameter int unsigned N     = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [SEL_W-1:0] select;
    logic             q;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     d;
    logic [N-1:0]     lane_mask;
    logic             dup_err;
    logic [7:0]       word_cnt;

    // Producer of lane samples and consumer of gathered words.
    modport master (
        output in_valid, select, q, out_ready,
        input  in_ready, out_valid, d, lane_mask, dup_err, word_cnt
    );

    // The gather block itself.
    modport slave (
        input  in_valid, select, q, out_ready,
        output in_ready, out_valid, d, lane_mask, dup_err, word_cnt
    );
endinterface

// File: rtl/mux_gather.sv
// Rebuilds an N-bit word from (select, q) lane samples produced by a
// 4:1 lane multiplexer and hands it out on a valid/ready port.
module mux_gather #(
    parameter int unsigned SEL_W = 2,
    parameter int unsigned N     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    mux_gather_if.slave bus
);
    logic [N-1:0] shadow_q, shadow_d;
    logic [N-1:0] mask_q, mask_d;
    logic [N-1:0] d_q, d_d;
    logic         out_valid_q, out_valid_d;
    logic         dup_err_q, dup_err_d;
    logic [7:0]   word_cnt_q, word_cnt_d;

    logic         accept;
    logic         slot_free;
    logic         drain;

    assign bus.in_ready  = ~(&mask_q);
    assign bus.lane_mask = mask_q;
    assign bus.d         = d_q;
    assign bus.out_valid = out_valid_q;
    assign bus.dup_err   = dup_err_q;
    assign bus.word_cnt  = word_cnt_q;

    assign accept    = bus.in_valid & ~(&mask_q);
    assign slot_free = ~out_valid_q | bus.out_ready;
    assign drain     = out_valid_q & bus.out_ready;

    // Next-state: merge the accepted lane, then move a full gather into the
    // output slot whenever the slot is free. Checking the merged mask covers
    // both the final-lane edge and a previously stalled full mask.
    always_comb begin
        shadow_d    = shadow_q;
        mask_d      = mask_q;
        d_d         = d_q;
        out_valid_d = out_valid_q;
        dup_err_d   = 1'b0;
        word_cnt_d  = word_cnt_q;

        if (accept) begin
            shadow_d[bus.select] = bus.q;
            mask_d[bus.select]   = 1'b1;
            dup_err_d            = mask_q[bus.select];
        end

        if (drain) begin
            out_valid_d = 1'b0;
            word_cnt_d  = word_cnt_q + 8'd1;
        end

        if ((&mask_d) && slot_free) begin
            d_d         = shadow_d;
            out_valid_d = 1'b1;
            mask_d      = '0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q    <= '0;
            mask_q      <= '0;
            d_q         <= '0;
            out_valid_q <= 1'b0;
            dup_err_q   <= 1'b0;
            word_cnt_q  <= '0;
        end else begin
            shadow_q    <= shadow_d;
            mask_q      <= mask_d;
            d_q         <= d_d;
            out_valid_q <= out_valid_d;
            dup_err_q   <= dup_err_d;
            word_cnt_q  <= word_cnt_d;
        end
    end
endmodule

// File: tb/tb_mux_gather.sv
// Directed bench for mux_gather: reset, in-order sweep, out-of-order lanes,
// duplicate lanes, backpressure, same-edge completion/drain and counter wrap.
module tb_mux_gather;
    logic clk;
    logic rst_n;
    int   nvec;
    int   nerr;

    mux_gather_if #(.SEL_W(2), .N(4)) bus ();

    mux_gather #(.SEL_W(2), .N(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send(input logic [1:0] sel, input logic bitv);
        bus.in_valid = 1'b1;
        bus.select   = sel;
        bus.q        = bitv;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [3:0] w);
        for (int l = 0; l < 4; l++) begin
            send(l[1:0], w[l]);
        end
    endtask

    task automatic test_reset();
        bus.out_ready = 1'b1;
        send_word(4'hF);
        idle();
        send(2'd0, 1'b1);
        send(2'd2, 1'b1);
        nvec++;
        if (bus.lane_mask !== 4'b0101) begin
            nerr++;
            $display("FAIL rst_pre_mask got %b exp %b", bus.lane_mask, 4'b0101);
        end
        nvec++;
        if (bus.word_cnt !== 8'd1) begin
            nerr++;
            $display("FAIL rst_pre_cnt got %0d exp 1", bus.word_cnt);
        end
        #2 rst_n = 1'b0;
        #1;
        nvec++;
        if (bus.lane_mask !== 4'b0000) begin
            nerr++;
            $display("FAIL rst_mask got %b exp 0000", bus.lane_mask);
        end
        nvec++;
        if (bus.d !== 4'h0) begin
            nerr++;
            $display("FAIL rst_d got %h exp 0", bus.d);
        end
        nvec++;
        if (bus.out_valid !== 1'b0 || bus.dup_err !== 1'b0) begin
            nerr++;
            $display("FAIL rst_flags got ov=%b dup=%b exp 0 0", bus.out_valid, bus.dup_err);
        end
        nvec++;
        if (bus.word_cnt !== 8'd0) begin
            nerr++;
            $display("FAIL rst_cnt got %0d exp 0", bus.word_cnt);
        end
        nvec++;
        if (bus.in_ready !== 1'b1) begin
            nerr++;
            $display("FAIL rst_in_ready got %b exp 1", bus.in_ready);
        end
        rst_n = 1'b1;
        idle();
        nvec++;
        if (bus.out_valid !== 1'b0 || bus.lane_mask !== 4'b0000) begin
            nerr++;
            $display("FAIL rst_post got ov=%b mask=%b exp 0 0000", bus.out_valid, bus.lane_mask);
        end
    endtask

    task automatic test_sweep();
        logic [3:0] w;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            w = i[3:0];
            send(2'd0, w[0]);
            nvec++;
            if (bus.out_valid !== 1'b0) begin
                nerr++;
                $display("FAIL sweep_pulse word %0d got ov=%b exp 0", i, bus.out_valid);
            end
            send(2'd1, w[1]);
            send(2'd2, w[2]);
            send(2'd3, w[3]);
            nvec++;
            if (bus.out_valid !== 1'b1 || bus.d !== w) begin
                nerr++;
                $display("FAIL sweep_word %0d got ov=%b d=%h exp 1 %h", i, bus.out_valid, bus.d, w);
            end
        end
        idle();
        nvec++;
        if (bus.word_cnt !== 8'd16 || bus.out_valid !== 1'b0) begin
            nerr++;
            $display("FAIL sweep_cnt got cnt=%0d ov=%b exp 16 0", bus.word_cnt, bus.out_valid);
        end
    endtask

    task automatic test_out_of_order();
        logic [1:0] sels [4];
        logic       bits [4];
        int         dups;
        sels = '{2'd3, 2'd0, 2'd2, 2'd1};
        bits = '{1'b1, 1'b0, 1'b1, 1'b1};
        dups = 0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            send(sels[k], bits[k]);
            if (bus.dup_err !== 1'b0) dups++;
        end
        nvec++;
        if (bus.out_valid !== 1'b1 || bus.d !== 4'b1110) begin
            nerr++;
            $display("FAIL ooo_word got ov=%b d=%b exp 1 1110", bus.out_valid, bus.d);
        end
        idle();
        if (bus.dup_err !== 1'b0) dups++;
        nvec++;
        if (dups != 0) begin
            nerr++;
            $display("FAIL ooo_dup got %0d dup pulses exp 0", dups);
        end
        nvec++;
        if (bus.word_cnt !== 8'd17) begin
            nerr++;
            $display("FAIL ooo_cnt got %0d exp 17", bus.word_cnt);
        end
    endtask

    task automatic test_dup();
        bus.out_ready = 1'b1;
        send(2'd0, 1'b1);
        nvec++;
        if (bus.dup_err !== 1'b0) begin
            nerr++;
            $display("FAIL dup_first got %b exp 0", bus.dup_err);
        end
        send(2'd0, 1'b0);
        nvec++;
        if (bus.dup_err !== 1'b1 || bus.lane_mask !== 4'b0001) begin
            nerr++;
            $display("FAIL dup_pulse got dup=%b mask=%b exp 1 0001", bus.dup_err, bus.lane_mask);
        end
        send(2'd1, 1'b1);
        nvec++;
        if (bus.dup_err !== 1'b0) begin
            nerr++;
            $display("FAIL dup_clear got %b exp 0", bus.dup_err);
        end
        send(2'd2, 1'b1);
        send(2'd3, 1'b1);
        nvec++;
        if (bus.out_valid !== 1'b1 || bus.d !== 4'b1110) begin
            nerr++;
            $display("FAIL dup_word got ov=%b d=%b exp 1 1110", bus.out_valid, bus.d);
        end
        idle();
        nvec++;
        if (bus.word_cnt !== 8'd18) begin
            nerr++;
            $display("FAIL dup_cnt got %0d exp 18", bus.word_cnt);
        end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        send_word(4'hA);
        nvec++;
        if (bus.out_valid !== 1'b1 || bus.d !== 4'hA) begin
            nerr++;
            $display("FAIL bp_first got ov=%b d=%h exp 1 a", bus.out_valid, bus.d);
        end
        send(2'd0, 1'b1);
        send(2'd1, 1'b0);
        nvec++;
        if (bus.d !== 4'hA || bus.in_ready !== 1'b1) begin
            nerr++;
            $display("FAIL bp_hold got d=%h rdy=%b exp a 1", bus.d, bus.in_ready);
        end
        send(2'd2, 1'b1);
        send(2'd3, 1'b0);
        nvec++;
        if (bus.in_ready !== 1'b0 || bus.lane_mask !== 4'hF) begin
            nerr++;
            $display("FAIL bp_stall got rdy=%b mask=%h exp 0 f", bus.in_ready, bus.lane_mask);
        end
        idle();
        nvec++;
        if (bus.d !== 4'hA || bus.out_valid !== 1'b1 || bus.word_cnt !== 8'd18) begin
            nerr++;
            $display("FAIL bp_stable got d=%h ov=%b cnt=%0d exp a 1 18", bus.d, bus.out_valid, bus.word_cnt);
        end
        bus.out_ready = 1'b1;
        idle();
        bus.out_ready = 1'b0;
        nvec++;
        if (bus.d !== 4'h5 || bus.out_valid !== 1'b1) begin
            nerr++;
            $display("FAIL bp_release got d=%h ov=%b exp 5 1", bus.d, bus.out_valid);
        end
        nvec++;
        if (bus.in_ready !== 1'b1 || bus.lane_mask !== 4'h0 || bus.word_cnt !== 8'd19) begin
            nerr++;
            $display("FAIL bp_release_st got rdy=%b mask=%h cnt=%0d exp 1 0 19", bus.in_ready, bus.lane_mask, bus.word_cnt);
        end
        idle();
        bus.out_ready = 1'b1;
        idle();
        nvec++;
        if (bus.out_valid !== 1'b0 || bus.word_cnt !== 8'd20) begin
            nerr++;
            $display("FAIL bp_drain got ov=%b cnt=%0d exp 0 20", bus.out_valid, bus.word_cnt);
        end
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b0;
        send_word(4'h3);
        send(2'd0, 1'b0);
        send(2'd1, 1'b0);
        send(2'd2, 1'b1);
        nvec++;
        if (bus.d !== 4'h3 || bus.out_valid !== 1'b1) begin
            nerr++;
            $display("FAIL b2b_hold got d=%h ov=%b exp 3 1", bus.d, bus.out_valid);
        end
        bus.out_ready = 1'b1;
        send(2'd3, 1'b1);
        nvec++;
        if (bus.d !== 4'hC || bus.out_valid !== 1'b1 || bus.word_cnt !== 8'd21) begin
            nerr++;
            $display("FAIL b2b_same_edge got d=%h ov=%b cnt=%0d exp c 1 21", bus.d, bus.out_valid, bus.word_cnt);
        end
        idle();
        nvec++;
        if (bus.out_valid !== 1'b0 || bus.word_cnt !== 8'd22) begin
            nerr++;
            $display("FAIL b2b_drain got ov=%b cnt=%0d exp 0 22", bus.out_valid, bus.word_cnt);
        end
    endtask

    task automatic test_wrap();
        logic [3:0] w;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 233; k++) begin
            w = k[3:0];
            send_word(w);
        end
        idle();
        nvec++;
        if (bus.word_cnt !== 8'd255) begin
            nerr++;
            $display("FAIL wrap_255 got %0d exp 255", bus.word_cnt);
        end
        send_word(4'h9);
        nvec++;
        if (bus.out_valid !== 1'b1 || bus.d !== 4'h9) begin
            nerr++;
            $display("FAIL wrap_word got ov=%b d=%h exp 1 9", bus.out_valid, bus.d);
        end
        idle();
        nvec++;
        if (bus.word_cnt !== 8'd0) begin
            nerr++;
            $display("FAIL wrap_0 got %0d exp 0", bus.word_cnt);
        end
        nvec++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.lane_mask !== 4'h0 || bus.dup_err !== 1'b0) begin
            nerr++;
            $display("FAIL wrap_side got ov=%b rdy=%b mask=%h dup=%b exp 0 1 0 0", bus.out_valid, bus.in_ready, bus.lane_mask, bus.dup_err);
        end
    endtask

    initial begin
        nvec          = 0;
        nerr          = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.select    = '0;
        bus.q         = 1'b0;
        bus.out_ready = 1'b0;
        #12 rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_sweep();
        test_out_of_order();
        test_dup();
        test_backpressure();
        test_back_to_back();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
